// File: rtl/wc_mem_pkg.sv
// rtl/wc_mem_pkg.sv - shared data-memory access types, size codes, LSU states and byte-enable helper
package wc_mem_pkg;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic [1:0] size;
        logic       sign;
    } mem_ctrl_t;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] mem_be(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            MEM_SIZE_B: mem_be = 4'b0001 << addr;
            MEM_SIZE_H: mem_be = addr[1] ? 4'b1100 : 4'b0011;
            MEM_SIZE_W: mem_be = 4'b1111;
            default:    mem_be = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - lane select and sign/zero extension of a raw memory word
module mem_load_align
    import wc_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (i_offset)
            2'd0:    byte_sel = i_word[7:0];
            2'd1:    byte_sel = i_word[15:8];
            2'd2:    byte_sel = i_word[23:16];
            default: byte_sel = i_word[31:24];
        endcase
        half_sel = i_offset[1] ? i_word[31:16] : i_word[15:0];

        // sign=1 selects zero extension
        case (i_size)
            MEM_SIZE_B: o_data = i_sign ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            MEM_SIZE_H: o_data = i_sign ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default:    o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_lsu_initiator.sv
// rtl/mem_lsu_initiator.sv - MEM-stage load/store initiator on a valid/ready request, valid response bus
module mem_lsu_initiator
    import wc_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_memAddr,
    input  logic [31:0] i_writeData,
    input  mem_ctrl_t   i_ctrlMEM,
    output logic [31:0] o_readData,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    output logic        o_req_we,
    output logic [3:0]  o_req_be,
    output logic [31:0] o_req_wdata,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_rdata
);

    localparam logic [TO_W-1:0] TMO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [29:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic [31:0]     rdata_q, rdata_d;

    logic        access;
    logic        illegal;
    logic        legal;
    logic [31:0] wdata_rep;
    logic [31:0] aligned;

    mem_load_align u_align (
        .i_word   (i_rsp_rdata),
        .i_offset (off_q),
        .i_size   (size_q),
        .i_sign   (sign_q),
        .o_data   (aligned)
    );

    always_comb begin
        access = i_ctrlMEM.memRead | i_ctrlMEM.memWrite;
        case (i_ctrlMEM.size)
            MEM_SIZE_B: illegal = 1'b0;
            MEM_SIZE_H: illegal = i_memAddr[0];
            MEM_SIZE_W: illegal = |i_memAddr[1:0];
            default:    illegal = 1'b1;
        endcase
        legal = access & ~illegal;

        case (i_ctrlMEM.size)
            MEM_SIZE_B: wdata_rep = {4{i_writeData[7:0]}};
            MEM_SIZE_H: wdata_rep = {2{i_writeData[15:0]}};
            default:    wdata_rep = i_writeData;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        off_d        = off_q;
        size_d       = size_q;
        sign_d       = sign_q;
        rdata_d      = rdata_q;
        o_misaligned = 1'b0;
        o_bus_err    = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    if (illegal) begin
                        o_misaligned = 1'b1;
                    end else begin
                        // a simultaneous read+write is handled as a write
                        addr_d  = i_memAddr[31:2];
                        we_d    = i_ctrlMEM.memWrite;
                        be_d    = i_ctrlMEM.memWrite ? mem_be(i_ctrlMEM.size, i_memAddr[1:0]) : 4'b0000;
                        wdata_d = wdata_rep;
                        off_d   = i_memAddr[1:0];
                        size_d  = i_ctrlMEM.size;
                        sign_d  = i_ctrlMEM.sign;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (i_req_ready) begin
                    state_d = we_q ? DONE : RSP;
                end
            end
            RSP: begin
                cnt_d = cnt_q + 1'b1;
                if (i_rsp_valid) begin
                    rdata_d = aligned;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    o_bus_err = 1'b1;
                    rdata_d   = 32'h0;
                    cnt_d     = '0;
                    state_d   = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_stall     = ((state_q == IDLE) & legal) | (state_q == REQ) | (state_q == RSP);
    assign o_req_valid = (state_q == REQ);
    assign o_req_addr  = {addr_q, 2'b00};
    assign o_req_we    = we_q;
    assign o_req_be    = be_q;
    assign o_req_wdata = wdata_q;
    assign o_readData  = rdata_q;

endmodule

// File: tb/tb_mem_lsu_initiator.sv
// tb/tb_mem_lsu_initiator.sv - vector table plus request/response scoreboard for mem_lsu_initiator
module tb_mem_lsu_initiator;
    import wc_mem_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_ctrl_t   ctrl;
    logic [31:0] o_readData;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_bus_err;
    logic        o_req_valid;
    logic        req_ready;
    logic [31:0] o_req_addr;
    logic        o_req_we;
    logic [3:0]  o_req_be;
    logic [31:0] o_req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    mem_lsu_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_memAddr    (addr),
        .i_writeData  (wdata),
        .i_ctrlMEM    (ctrl),
        .o_readData   (o_readData),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err),
        .o_req_valid  (o_req_valid),
        .i_req_ready  (req_ready),
        .o_req_addr   (o_req_addr),
        .o_req_we     (o_req_we),
        .o_req_be     (o_req_be),
        .o_req_wdata  (o_req_wdata),
        .i_rsp_valid  (rsp_valid),
        .i_rsp_rdata  (rsp_rdata)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  size;
        bit          sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] rsp_word;
        bit          legal;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] last_rdata = 32'h0;
    req_t        req_q[$];
    logic [31:0] rd_q[$];
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                                input logic [31:0] a, input logic [31:0] wdi, input int rdy,
                                input int rsp, input logic [31:0] rw, input bit lg,
                                input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rdat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = sz; v.sign = sg; v.addr = a; v.wdata = wdi;
        v.rdy_dly = rdy; v.rsp_dly = rsp; v.rsp_word = rw; v.legal = lg;
        v.be = be; v.wd = wd; v.rdata = rdat;
        return v;
    endfunction

    task automatic idle_inputs();
        ctrl.memRead = 1'b0; ctrl.memWrite = 1'b0; ctrl.size = 2'b00; ctrl.sign = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
    endtask

    task automatic run_vec(input vec_t v);
        req_t er;
        logic [31:0] erd;
        int k;
        bit fin;
        @(negedge clk);
        ctrl.memRead = v.rd; ctrl.memWrite = v.wr; ctrl.size = v.size; ctrl.sign = v.sign;
        addr = v.addr; wdata = v.wdata; req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'hBAD0BAD0;
        #1;
        chk("idle_stall", o_stall, v.legal);
        chk("idle_misaligned", o_misaligned, !v.legal);
        chk("idle_req_valid", o_req_valid, 0);
        if (!v.legal) begin
            chk("illegal_rdata_hold", o_readData, last_rdata);
            @(negedge clk);
            idle_inputs();
            #1;
            chk("illegal_no_req", o_req_valid, 0);
            chk("illegal_stall", o_stall, 0);
            chk("illegal_rdata_after", o_readData, last_rdata);
            return;
        end
        req_q.push_back('{addr: {v.addr[31:2], 2'b00}, we: v.wr, be: v.be, wdata: v.wd});
        if (!v.wr) rd_q.push_back(v.rdata);

        for (int d = 0; d <= v.rdy_dly; d++) begin
            @(negedge clk);
            ctrl.size = 2'($urandom); ctrl.sign = ~v.sign;
            addr = $urandom; wdata = $urandom;
            req_ready = (d == v.rdy_dly);
            #1;
            chk("req_valid", o_req_valid, 1);
            chk("req_stall", o_stall, 1);
            if (req_q.size() == 0) begin
                chk("req_scoreboard_empty", 1, 0);
            end else begin
                er = req_q[0];
                chk("req_addr", o_req_addr, er.addr);
                chk("req_we", o_req_we, er.we);
                chk("req_be", o_req_be, er.be);
                if (er.we) chk("req_wdata", o_req_wdata, er.wdata);
                if (d == v.rdy_dly) void'(req_q.pop_front());
            end
        end

        if (!v.wr) begin
            k = 0;
            fin = 0;
            while (!fin && k < TMO + 4) begin
                @(negedge clk);
                req_ready = 1'b0;
                rsp_valid = (v.rsp_dly == k);
                rsp_rdata = (v.rsp_dly == k) ? v.rsp_word : 32'hBAD0BAD0;
                #1;
                chk("rsp_stall", o_stall, 1);
                chk("rsp_req_valid", o_req_valid, 0);
                chk("rsp_bus_err", o_bus_err, (v.rsp_dly != k) && (k == TMO - 1));
                if (rsp_valid || k == TMO - 1) fin = 1;
                k++;
            end
            if (!fin) chk("rsp_cycle_budget", 0, 1);
        end

        @(negedge clk);
        idle_inputs();
        rsp_valid = 1'b1; rsp_rdata = 32'hBAD0BAD0;
        #1;
        chk("done_stall", o_stall, 0);
        chk("done_req_valid", o_req_valid, 0);
        chk("done_bus_err", o_bus_err, 0);
        if (!v.wr) begin
            if (rd_q.size() == 0) begin
                chk("rd_scoreboard_empty", 1, 0);
            end else begin
                erd = rd_q.pop_front();
                chk("load_rdata", o_readData, erd);
                last_rdata = erd;
            end
        end else begin
            chk("store_rdata_hold", o_readData, last_rdata);
        end
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("idle_rdata_hold", o_readData, last_rdata);
    endtask

    initial begin
        rst_n = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_readData", o_readData, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_req_valid", o_req_valid, 0);
        chk("rst_req_be", o_req_be, 0);
        rst_n = 1'b1;

        vecs.push_back(mk(0, 1, MEM_SIZE_W, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1, 4'hF, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 1, MEM_SIZE_B, 0, 32'h203, 32'h000000A5, 0, 0, 0, 1, 4'h8, 32'hA5A5A5A5, 0));
        vecs.push_back(mk(1, 0, MEM_SIZE_B, 0, 32'h202, 0, 0, 0, 32'h12807654, 1, 4'h0, 0, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, MEM_SIZE_B, 1, 32'h202, 0, 1, 1, 32'h12807654, 1, 4'h0, 0, 32'h00000080));
        vecs.push_back(mk(1, 0, MEM_SIZE_H, 0, 32'h102, 0, 3, 0, 32'h80011234, 1, 4'h0, 0, 32'hFFFF8001));
        vecs.push_back(mk(1, 0, MEM_SIZE_W, 0, 32'h101, 0, 0, 0, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, MEM_SIZE_H, 0, 32'h003, 32'h1234, 0, 0, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, MEM_SIZE_H, 0, 32'h002, 32'h1234BEEF, 2, 0, 0, 1, 4'hC, 32'hBEEFBEEF, 0));
        vecs.push_back(mk(1, 0, MEM_SIZE_H, 1, 32'h100, 0, 0, 0, 32'hAAAAF00D, 1, 4'h0, 0, 32'h0000F00D));
        vecs.push_back(mk(1, 0, MEM_SIZE_W, 0, 32'h104, 0, 1, 2, 32'h89ABCDEF, 1, 4'h0, 0, 32'h89ABCDEF));
        vecs.push_back(mk(1, 0, 2'b11, 0, 32'h000, 0, 0, 0, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(1, 0, MEM_SIZE_B, 1, 32'h201, 0, 0, TMO - 1, 32'h0000FE00, 1, 4'h0, 0, 32'h000000FE));
        vecs.push_back(mk(1, 0, MEM_SIZE_W, 0, 32'h108, 0, 0, -1, 0, 1, 4'h0, 0, 32'h0));
        vecs.push_back(mk(1, 1, MEM_SIZE_B, 0, 32'h001, 32'h00000077, 0, 0, 0, 1, 4'h2, 32'h77777777, 0));
        vecs.push_back(mk(1, 0, MEM_SIZE_B, 0, 32'h003, 0, 0, 0, 32'h7F000000, 1, 4'h0, 0, 32'h0000007F));

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset asserted while waiting for a read response
        @(negedge clk);
        ctrl.memRead = 1'b1; ctrl.memWrite = 1'b0; ctrl.size = MEM_SIZE_W; ctrl.sign = 1'b0;
        addr = 32'h10C; wdata = 32'h55AA55AA;
        #1;
        chk("rst_seq_idle_stall", o_stall, 1);
        @(negedge clk);
        idle_inputs();
        req_ready = 1'b1;
        #1;
        chk("rst_seq_req_valid", o_req_valid, 1);
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        chk("rst_seq_rsp_stall", o_stall, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", o_stall, 0);
        chk("async_rst_req_valid", o_req_valid, 0);
        chk("async_rst_readData", o_readData, 0);
        chk("async_rst_req_addr", o_req_addr, 0);
        chk("async_rst_req_we", o_req_we, 0);
        chk("async_rst_req_be", o_req_be, 0);
        chk("async_rst_bus_err", o_bus_err, 0);
        chk("async_rst_misaligned", o_misaligned, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 32'h0;
        #1;
        chk("post_rst_stall", o_stall, 0);
        run_vec(mk(1, 0, MEM_SIZE_W, 0, 32'h10C, 0, 0, 0, 32'h13579BDF, 1, 4'h0, 0, 32'h13579BDF));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
